// File: rtl/pmp_seq_checker.sv
// Sequential PMP checker: scans TOR entries one per cycle with a single matcher.
// Optional denied-response counter is built only when PMP_DENY_CNT_EN is defined.
module pmp_seq_checker #(
  parameter int NUM_ENTRIES = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [31:0]                req_addr,
  input  logic [1:0]                 req_size,
  input  logic [1:0]                 req_type,
  input  logic                       req_priv_m,
  input  logic [8*NUM_ENTRIES-1:0]   pmp_cfg,
  input  logic [32*NUM_ENTRIES-1:0]  pmp_addr,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic                       rsp_allow,
  output logic                       rsp_hit,
  output logic [3:0]                 rsp_entry,
  output logic [15:0]                deny_cnt
);

  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

  localparam logic [3:0] LAST = 4'(NUM_ENTRIES - 1);

  state_t      state;
  logic [3:0]  idx;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic [1:0]  type_q;
  logic        priv_q;

  logic [7:0]  cfg_arr  [16];
  logic [31:0] addr_arr [16];

  // Unused entry slots are padded so idx can address a fixed 16-deep table.
  for (genvar g = 0; g < 16; g++) begin : g_unpack
    if (g < NUM_ENTRIES) begin : g_live
      assign cfg_arr[g]  = pmp_cfg[8*g +: 8];
      assign addr_arr[g] = pmp_addr[32*g +: 32];
    end else begin : g_pad
      assign cfg_arr[g]  = '0;
      assign addr_arr[g] = '0;
    end
  end

  logic [7:0]  cur_cfg;
  logic [31:0] lo;
  logic [31:0] hi;
  logic [31:0] end_addr;
  logic        tor_match;
  logic        perm;
  logic        hit_allow;
  logic        miss_allow;
  logic        unused_cfg_bits;

  always_comb begin
    cur_cfg    = cfg_arr[idx];
    hi         = addr_arr[idx];
    lo         = (idx == 4'd0) ? '0 : addr_arr[idx - 4'd1];
    end_addr   = addr_q + {30'd0, size_q};
    tor_match  = (cur_cfg[4:3] == 2'b01) && (addr_q <= end_addr) &&
                 (addr_q >= lo) && (end_addr < hi);
    perm = 1'b0;
    case (type_q)
      2'b00:   perm = cur_cfg[0];
      2'b01:   perm = cur_cfg[1];
      2'b10:   perm = cur_cfg[2];
      default: perm = 1'b0;
    endcase
    hit_allow  = (type_q != 2'b11) && ((priv_q && !cur_cfg[7]) || perm);
    miss_allow = (type_q != 2'b11) && priv_q;
  end

  assign unused_cfg_bits = ^cur_cfg[6:5];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      addr_q    <= '0;
      size_q    <= '0;
      type_q    <= '0;
      priv_q    <= 1'b0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_allow <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_entry <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!req_ready) begin
            req_ready <= 1'b1;
          end else if (req_valid) begin
            addr_q    <= req_addr;
            size_q    <= req_size;
            type_q    <= req_type;
            priv_q    <= req_priv_m;
            idx       <= '0;
            req_ready <= 1'b0;
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (tor_match) begin
            rsp_hit   <= 1'b1;
            rsp_entry <= idx;
            rsp_allow <= hit_allow;
            state     <= RESP;
          end else if (idx == LAST) begin
            rsp_hit   <= 1'b0;
            rsp_entry <= '0;
            rsp_allow <= miss_allow;
            state     <= RESP;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        RESP: begin
          // Decision is latched one edge before rsp_valid rises.
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            idx       <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PMP_DENY_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deny_cnt <= '0;
    end else if (rsp_valid && rsp_ready && !rsp_allow && (deny_cnt != '1)) begin
      deny_cnt <= deny_cnt + 16'd1;
    end
  end
`else
  assign deny_cnt = '0;
`endif

endmodule

// File: tb/tb_pmp_seq_checker.sv
// Randomized and directed bench for pmp_seq_checker against a behavioural PMP model.
// Define PMP_DENY_CNT_EN for both files to exercise the denial counter.
module tb_pmp_seq_checker;
  localparam int N = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic [31:0]     req_addr;
  logic [1:0]      req_size;
  logic [1:0]      req_type;
  logic            req_priv_m;
  logic [8*N-1:0]  pmp_cfg;
  logic [32*N-1:0] pmp_addr;
  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_allow;
  logic            rsp_hit;
  logic [3:0]      rsp_entry;
  logic [15:0]     deny_cnt;

  int total = 0;
  int bad   = 0;
  int deny_model = 0;

  logic [7:0]  cfg_m  [N];
  logic [31:0] addr_m [N];

  pmp_seq_checker #(.NUM_ENTRIES(N)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_size(req_size), .req_type(req_type),
    .req_priv_m(req_priv_m), .pmp_cfg(pmp_cfg), .pmp_addr(pmp_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_allow(rsp_allow),
    .rsp_hit(rsp_hit), .rsp_entry(rsp_entry), .deny_cnt(deny_cnt)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      pmp_cfg[8*i +: 8]   = cfg_m[i];
      pmp_addr[32*i +: 32] = addr_m[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cfg();
    for (int i = 0; i < N; i++) begin
      cfg_m[i]  = '0;
      addr_m[i] = '0;
    end
  endtask

  function automatic int exp_deny();
`ifdef PMP_DENY_CNT_EN
    return deny_model;
`else
    return 0;
`endif
  endfunction

  // Region i covers [addr_m[i-1], addr_m[i]) (or [0, addr_m[0])); the access
  // spans a..a+size and must not run past 2^32.
  function automatic void model(input logic [31:0] a, input logic [1:0] sz,
                                input logic [1:0] ty, input bit pm,
                                output bit hit, output logic [3:0] ent,
                                output bit allow, output int lat);
    longint unsigned e;
    longint unsigned lo;
    bit perm;
    e   = 64'(a) + 64'(sz);
    hit = 1'b0;
    ent = '0;
    lat = N + 1;
    for (int i = 0; i < N; i++) begin
      if (i == 0) lo = 0;
      else        lo = 64'(addr_m[i-1]);
      if (!hit && cfg_m[i][4:3] == 2'b01 && e < 64'h1_0000_0000 &&
          64'(a) >= lo && e < 64'(addr_m[i])) begin
        hit = 1'b1;
        ent = 4'(i);
        lat = i + 2;
      end
    end
    case (ty)
      2'd0:    perm = cfg_m[ent][0];
      2'd1:    perm = cfg_m[ent][1];
      2'd2:    perm = cfg_m[ent][2];
      default: perm = 1'b0;
    endcase
    if (ty == 2'd3) allow = 1'b0;
    else if (hit)   allow = (pm && !cfg_m[ent][7]) || perm;
    else            allow = pm;
  endfunction

  task automatic run_req(input logic [31:0] a, input logic [1:0] sz,
                         input logic [1:0] ty, input bit pm, input int hold);
    bit eh;
    logic [3:0] ee;
    bit ea;
    int el;
    int n;
    model(a, sz, ty, pm, eh, ee, ea, el);
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    check("req_ready_idle", req_ready, 1);
    req_addr = a; req_size = sz; req_type = ty; req_priv_m = pm; req_valid = 1'b1;
    tick();
    req_valid  = 1'b0;
    req_addr   = $urandom;
    req_size   = 2'($urandom);
    req_type   = 2'($urandom);
    req_priv_m = 1'($urandom);
    n = 0;
    while (n < N + 8) begin
      tick();
      n++;
      if (rsp_valid) break;
    end
    check("rsp_latency", n, el);
    check("req_ready_busy", req_ready, 0);
    check("rsp_hit", rsp_hit, eh);
    check("rsp_entry", rsp_entry, ee);
    check("rsp_allow", rsp_allow, ea);
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_valid", rsp_valid, 1);
      check("hold_ready", req_ready, 0);
      check("hold_hit", rsp_hit, eh);
      check("hold_entry", rsp_entry, ee);
      check("hold_allow", rsp_allow, ea);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    if (!ea && deny_model < 65535) deny_model++;
    check("rsp_valid_drop", rsp_valid, 0);
    check("deny_cnt", deny_cnt, exp_deny());
  endtask

  initial begin
    bit seen;
    int n;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_size = '0; req_type = '0;
    req_priv_m = 1'b0; rsp_ready = 1'b0;
    clear_cfg();

    tick(); tick();
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_allow", rsp_allow, 0);
    check("rst_rsp_hit", rsp_hit, 0);
    check("rst_rsp_entry", rsp_entry, 0);
    check("rst_deny_cnt", deny_cnt, 0);
    rst = 1'b0;
    tick();
    check("post_rst_ready", req_ready, 1);

    // Single TOR entry below 0x100, U-mode read.
    cfg_m[0] = 8'h09; addr_m[0] = 32'h100;
    run_req(32'hFC, 2'd2, 2'd0, 1'b0, 0);

    // Entry 3 read-only region, U-mode write with stalled consumer.
    cfg_m[3] = 8'h09; addr_m[2] = 32'h200; addr_m[3] = 32'h300;
    run_req(32'h250, 2'd0, 2'd1, 1'b0, 5);

    // No eligible entries: full scan, allow follows privilege.
    clear_cfg();
    run_req(32'h0, 2'd0, 2'd0, 1'b1, 0);
    run_req(32'h0, 2'd0, 2'd0, 1'b0, 0);

    // Boundaries: wrap, end touching hi, start at lo.
    cfg_m[0] = 8'h0F; addr_m[0] = 32'h100;
    cfg_m[1] = 8'h0F; addr_m[1] = 32'h200;
    addr_m[14] = 32'hFFFF_FF00; cfg_m[15] = 8'h0F; addr_m[15] = 32'hFFFF_FFFF;
    run_req(32'hFFFF_FFFF, 2'd1, 2'd0, 1'b0, 0);
    run_req(32'hFFFF_FFFE, 2'd0, 2'd0, 1'b0, 0);
    run_req(32'hFE, 2'd2, 2'd0, 1'b0, 0);
    run_req(32'h100, 2'd0, 2'd0, 1'b0, 0);

    // Locked entry binds M-mode; type 3 is always denied.
    clear_cfg();
    cfg_m[0] = 8'h8B; addr_m[0] = 32'h1000;
    run_req(32'h10, 2'd0, 2'd2, 1'b1, 0);
    cfg_m[0] = 8'h0B;
    run_req(32'h10, 2'd0, 2'd2, 1'b1, 0);
    run_req(32'h10, 2'd0, 2'd3, 1'b1, 0);

    // Randomized configurations and requests clustered around region edges.
    for (int c = 0; c < 6; c++) begin
      logic [31:0] base;
      base = $urandom_range(0, 32'h1000);
      for (int i = 0; i < N; i++) begin
        base      = base + $urandom_range(0, 32'h80);
        addr_m[i] = base;
        cfg_m[i]  = 8'($urandom);
        if ($urandom_range(0, 1) == 0) cfg_m[i][4:3] = 2'b01;
      end
      for (int r = 0; r < 8; r++) begin
        logic [31:0] a;
        int j;
        j = $urandom_range(0, N - 1);
        a = addr_m[j] + 32'($urandom_range(0, 6)) - 32'd3;
        if ($urandom_range(0, 4) == 0) a = $urandom;
        run_req(a, 2'($urandom_range(0, 2)), 2'($urandom), 1'($urandom),
                $urandom_range(0, 2));
      end
    end

    // Reset during SCAN aborts without a response.
    clear_cfg();
    req_addr = 32'h40; req_size = '0; req_type = '0; req_priv_m = 1'b1; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    check("scan_rst_valid", rsp_valid, 0);
    check("scan_rst_ready", req_ready, 0);
    check("scan_rst_deny", deny_cnt, 0);
    deny_model = 0;
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < N + 4; k++) begin
      tick();
      if (rsp_valid) seen = 1'b1;
    end
    check("scan_rst_no_rsp", seen, 0);
    check("scan_rst_idle", req_ready, 1);

    // Reset during RESP drops the pending response.
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < N + 8) begin
      tick();
      n++;
    end
    check("resp_pending", rsp_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("resp_rst_valid", rsp_valid, 0);
    tick();
    rst = 1'b0;
    tick();
    check("resp_rst_idle_valid", rsp_valid, 0);

    // Three denials from a fresh counter.
    run_req(32'h80, 2'd0, 2'd1, 1'b0, 0);
    run_req(32'h84, 2'd1, 2'd0, 1'b0, 1);
    run_req(32'h88, 2'd2, 2'd3, 1'b1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/pmp_seq_checker.md
PMP_SEQ_CHECKER -- requirements
Module: pmp_seq_checker

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 16, number of PMP entries scanned (2..16).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port req_valid, input, 1, check request present.
REQ-005 SHALL have port req_ready, output, 1, block can accept a request.
REQ-006 SHALL have port req_addr, input, 32, unsigned access base address.
REQ-007 SHALL have port req_size, input, 2, access size: 00 byte, 01 half, 10 word.
REQ-008 SHALL have port req_type, input, 2, access type: 00 read, 01 write, 10 execute; 11 is always denied.
REQ-009 SHALL have port req_priv_m, input, 1, requester is in M-mode.
REQ-010 SHALL have port pmp_cfg, input, 8*NUM_ENTRIES, per-entry cfg byte: bit0 R, bit1 W, bit2 X, bits4:3 A, bit7 L.
REQ-011 SHALL have port pmp_addr, input, 32*NUM_ENTRIES, per-entry address register, entry i at bits 32i+31:32i.
REQ-012 SHALL have port rsp_valid, output, 1, result present.
REQ-013 SHALL have port rsp_ready, input, 1, consumer accepts result.
REQ-014 SHALL have port rsp_allow, output, 1, access permitted.
REQ-015 SHALL have port rsp_hit, output, 1, some entry matched.
REQ-016 SHALL have port rsp_entry, output, 4, index of matching entry; 0 when no hit.
REQ-017 SHALL have port deny_cnt, output, 16, denied-response count (see Configuration).

Function
REQ-018 SHALL implement FSM states IDLE, SCAN, RESP.
REQ-019 IDLE: req_ready=1; on req_valid, capture addr/size/type/priv_m, set idx=0, go to SCAN.
REQ-020 SCAN: req_ready=0; each cycle SHALL evaluate exactly one entry idx using a single TOR matcher.
REQ-021 TOR match SHALL be (addr <= addr+size) && (addr >= lo) && (addr+size < hi), 32-bit unsigned, no carry-out; lo = 0 for idx 0, else pmp_addr[idx-1]; hi = pmp_addr[idx].
REQ-022 Entry SHALL be eligible only if A == 01 (TOR); A of 00, 10, or 11 SHALL be treated as no match.
REQ-023 On the first eligible match, SHALL latch hit=1, entry=idx, and go to RESP; lowest index wins.
REQ-024 If idx == NUM_ENTRIES-1 with no match, SHALL go to RESP with hit=0.
REQ-025 Hit allow: if req_priv_m=1 and L=0, allow=1; otherwise allow = permission bit selected by req_type.
REQ-026 No-hit allow: allow = req_priv_m.
REQ-027 req_type 11 SHALL force allow=0 regardless of hit.
REQ-028 RESP: rsp_valid=1 with rsp_allow/hit/entry held stable until rsp_valid && rsp_ready, then go to IDLE.
REQ-029 Latency: request accepted at edge 0, entry k decided at edge k+1, rsp_valid high from edge k+2; worst-case no-hit gives rsp_valid at edge NUM_ENTRIES+1.
REQ-030 pmp_cfg and pmp_addr SHALL be sampled live during SCAN; they are not captured, and the system keeps them stable while req_ready=0.
REQ-031 A new request SHALL NOT be accepted in the cycle rsp handshake completes; the earliest is one cycle later in IDLE.
REQ-032 req inputs SHALL be ignored outside IDLE.

Reset
REQ-033 While rst=1: state=IDLE, idx=0, rsp_valid=0, rsp_allow=0, rsp_hit=0, rsp_entry=0, deny_cnt=0, req_ready=0.
REQ-034 After rst deasserts: req_ready=1 in IDLE at the next cycle.
REQ-035 Reset mid-SCAN or mid-RESP SHALL abort immediately and emit no response.

Configuration
REQ-036 With PMP_DENY_CNT_EN defined, deny_cnt SHALL increment by 1 at each rsp handshake where rsp_allow=0, saturating at 0xFFFF.
REQ-037 Without PMP_DENY_CNT_EN, deny_cnt SHALL be constant 0 and no counter register SHALL be present.

Verification
REQ-038 Entry0 TOR, cfg=0x09, addr0=0x100; U-mode read 0xFC size 10 -> rsp at edge 2: hit=1, entry=0, allow=1.
REQ-039 Entry0 TOR addr0=0x100; entry3 TOR R-only, addr2=0x200, addr3=0x300; U-mode write 0x250 -> rsp_valid at edge 5: hit=1, entry=3, allow=0.
REQ-040 All A=00; M-mode read 0x0 -> hit=0, allow=1, rsp_valid at edge NUM_ENTRIES+1; same request in U-mode -> allow=0.
REQ-041 Boundary cases: addr=0xFFFFFFFF size 01 (wrap) -> no match; addr+size == hi -> no match; addr == lo -> match.
REQ-042 M-mode exec on matching entry with L=1 and X=0 -> allow=0; same with L=0 -> allow=1.
REQ-043 rsp_ready held low 5 cycles -> outputs stable, req_ready=0; rst pulsed during SCAN -> no rsp_valid; with PMP_DENY_CNT_EN, 3 denials -> deny_cnt=3.
